// File: rtl/ram_2r1w_responder_pkg.sv
// Shared types and constants for the 2-read/1-write memory responder.
package ram_2r1w_pkg;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

  localparam int WR_COUNT_W = 16;
  localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = '1;

  // Saturating increment for the kernel write counter.
  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
    return (v == WR_COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_2r1w_responder_if.sv
// Kernel, debug and clear signals of the memory responder.
// master = kernel/bench side, slave = responder side.
interface ram_2r1w_responder_if
  import ram_2r1w_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]     raddr0;
  logic [WIDTH-1:0]      rdata0;
  logic [ADDR_W-1:0]     raddr1;
  logic [WIDTH-1:0]      rdata1;
  logic [ADDR_W-1:0]     waddr;
  logic [WIDTH-1:0]      wdata;
  logic                  wen;
  logic [ADDR_W-1:0]     debug_addr;
  logic [WIDTH-1:0]      debug_data;
  logic [ADDR_W-1:0]     debug_write_addr;
  logic [WIDTH-1:0]      debug_write_data;
  logic                  debug_write_en;
  logic                  clear_start;
  logic                  clear_busy;
  logic [WR_COUNT_W-1:0] wr_count;

  modport master (
    output raddr0, raddr1, waddr, wdata, wen, debug_addr,
           debug_write_addr, debug_write_data, debug_write_en, clear_start,
    input  rdata0, rdata1, debug_data, clear_busy, wr_count
  );

  modport slave (
    input  raddr0, raddr1, waddr, wdata, wen, debug_addr,
           debug_write_addr, debug_write_data, debug_write_en, clear_start,
    output rdata0, rdata1, debug_data, clear_busy, wr_count
  );
endinterface

// File: rtl/ram_2r1w_responder_read_port.sv
// Registered read port: write-first bypass, out-of-range reads return 0.
// Optional macro RAM_OUT_REG_EN adds a second output register (latency 2);
// the bypass only acts on the first stage.
module ram_read_port
  import ram_2r1w_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  mem_word,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  output logic [WIDTH-1:0]  data
);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic             in_range;
  logic             hit;
  logic [WIDTH-1:0] s1;

  assign in_range = ({1'b0, addr} < DEPTH_A);
  // w_en is already qualified by the write address being in range
  assign hit      = w_en && (w_addr == addr);

  // First stage: sample the word, newest write wins
  always_ff @(posedge clk or posedge rst)
    if (rst)            s1 <= '0;
    else if (!in_range) s1 <= '0;
    else if (hit)       s1 <= w_data;
    else                s1 <= mem_word;

`ifdef RAM_OUT_REG_EN
  logic [WIDTH-1:0] s2;

  // Second output stage, plain delay of the first
  always_ff @(posedge clk or posedge rst)
    if (rst) s2 <= '0;
    else     s2 <= s1;

  assign data = s2;
`else
  assign data = s1;
`endif

endmodule

// File: rtl/ram_2r1w_responder.sv
// Memory responder for HLS kernels: two registered read ports, one kernel
// write port, a debug read/write path (debug writes work during reset) and
// a clear engine that zeroes the array one word per cycle.
// Optional macro RAM_OUT_REG_EN: extra output register on all read ports.
module ram_2r1w_responder
  import ram_2r1w_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_2r1w_responder_if.slave   bus
);
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              NUM_PORTS = 3;
  localparam logic [ADDR_W:0] DEPTH_A   = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];

  clr_state_e            state, state_nx;
  logic [IDX_W-1:0]      ptr, ptr_nx;
  logic [WR_COUNT_W-1:0] cnt;

  logic              clr_we, dbg_we, krn_we, mem_we;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;

  // Write arbitration: clear > debug > kernel; losers are dropped
  always_comb begin
    clr_we = (state == CLR_RUN);
    dbg_we = bus.debug_write_en && !clr_we;
    krn_we = bus.wen && !rst && (state == CLR_IDLE) && !bus.debug_write_en;
    w_addr = bus.waddr;
    w_data = bus.wdata;
    if (clr_we) begin
      w_addr = ADDR_W'(ptr);
      w_data = '0;
    end else if (dbg_we) begin
      w_addr = bus.debug_write_addr;
      w_data = bus.debug_write_data;
    end
    mem_we = (clr_we || dbg_we || krn_we) && ({1'b0, w_addr} < DEPTH_A);
  end

  // Storage array; deliberately not reset so contents survive rst
  always_ff @(posedge clk)
    if (mem_we) mem[w_addr[IDX_W-1:0]] <= w_data;

  // Clear FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLR_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end

  // Clear FSM next state: walk the pointer over every word once
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      CLR_IDLE: if (bus.clear_start) state_nx = CLR_RUN;
      CLR_RUN: begin
        if (ptr == LAST) begin
          state_nx = CLR_IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      default: begin
        state_nx = CLR_IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  assign bus.clear_busy = (state == CLR_RUN);

  // Count kernel writes that actually landed in the array
  always_ff @(posedge clk or posedge rst)
    if (rst)                  cnt <= '0;
    else if (krn_we && mem_we) cnt <= sat_inc(cnt);

  assign bus.wr_count = cnt;

  // Read ports: 0 = raddr0, 1 = raddr1, 2 = debug
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  rd_word;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  rd_data;

  assign rd_addr = {bus.debug_addr, bus.raddr1, bus.raddr0};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rp
    assign rd_word[g] = mem[rd_addr[g][IDX_W-1:0]];

    ram_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rp (
      .clk      (clk),
      .rst      (rst),
      .addr     (rd_addr[g]),
      .mem_word (rd_word[g]),
      .w_en     (mem_we),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .data     (rd_data[g])
    );
  end

  assign bus.rdata0     = rd_data[0];
  assign bus.rdata1     = rd_data[1];
  assign bus.debug_data = rd_data[2];

endmodule
